// File: rtl/svnet_pixmap_tx_pkg.sv
// Shared types and sizing helpers for the SVNet pixmap stream source.
package svnet_pixmap_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } svnet_tx_state_t;

    typedef struct packed {
        logic valid;
        logic row_end;
        logic frame_end;
    } svnet_stream_meta_t;

    function automatic int words_per_row(input int width, input int ppc);
        return (width + ppc - 1) / ppc;
    endfunction

    function automatic int addr_width(input int width, input int height, input int ppc);
        int words;
        words = words_per_row(width, ppc) * height;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/svnet_pixmap_tx_if.sv
// Frame-buffer read port plus outgoing pixel stream of svnet_pixmap_tx.
interface svnet_pixmap_tx_if #(
    parameter int P_BPP    = 9,
    parameter int P_PPC    = 1,
    parameter int P_WIDTH  = 32,
    parameter int P_HEIGHT = 32
);
    localparam int ADDR_W = svnet_pixmap_tx_pkg::addr_width(P_WIDTH, P_HEIGHT, P_PPC);

    logic                     o_rd_en;
    logic [ADDR_W-1:0]        o_rd_addr;
    logic [P_PPC*P_BPP-1:0]   i_rd_data;
    logic [P_PPC-1:0]         o_valid;
    logic [P_PPC-1:0]         o_row_end;
    logic [P_PPC-1:0]         o_frame_end;
    logic [P_PPC*P_BPP-1:0]   o_data;

    modport master (
        output o_rd_en, o_rd_addr, o_valid, o_row_end, o_frame_end, o_data,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_valid, o_row_end, o_frame_end, o_data,
        output i_rd_data
    );
endinterface

// File: rtl/svnet_stream_delay.sv
// DEPTH x WIDTH register delay line with synchronous reset; shared by SVNet stream units.
module svnet_stream_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, so a reset mid-frame drops all in-flight beats.
    // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/svnet_pixmap_tx.sv
// Reads one frame from a word-addressed pixel RAM in raster order and emits it as an SVNet stream.
// Optional SVNET_PIXMAP_TX_LOOP_EN adds i_loop to repeat the latched frame without gaps.
module svnet_pixmap_tx
    import svnet_pixmap_tx_pkg::*;
#(
    parameter int P_BPP      = 9,
    parameter int P_PPC      = 1,
    parameter int P_WIDTH    = 32,
    parameter int P_HEIGHT   = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [$clog2(P_WIDTH):0]  i_width,
    input  logic [$clog2(P_HEIGHT):0] i_height,
    input  logic                      i_hold,
`ifdef SVNET_PIXMAP_TX_LOOP_EN
    input  logic                      i_loop,
`endif
    output logic                      o_busy,
    output logic                      o_done,
    svnet_pixmap_tx_if.master         bus
);
    localparam int WPR      = words_per_row(P_WIDTH, P_PPC);
    localparam int ADDR_W   = addr_width(P_WIDTH, P_HEIGHT, P_PPC);
    localparam int WIDTH_W  = $clog2(P_WIDTH) + 1;
    localparam int HEIGHT_W = $clog2(P_HEIGHT) + 1;
    localparam int WORD_W   = $clog2(WPR + 1);
    localparam int ROW_W    = $clog2(P_HEIGHT + 1);
    localparam int LANE_W   = P_PPC * P_BPP;
    localparam int META_W   = P_PPC * $bits(svnet_stream_meta_t) + 1;

    svnet_tx_state_t    state_q, state_d;
    logic [WIDTH_W-1:0] width_q, width_d, start_w;
    logic [HEIGHT_W-1:0] start_h;
    logic [WORD_W-1:0]  words_m1_q, words_m1_d, word_q, word_d;
    logic [ROW_W-1:0]   rows_m1_q, rows_m1_d, row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, row_base_q, row_base_d;
    logic               done_q, done_d, zero_done;
    logic [P_PPC-1:0]   valid_q, valid_d, row_end_q, row_end_d, frame_end_q, frame_end_d;
    logic [LANE_W-1:0]  data_q, data_d;

    logic issue, last_word, last_row, loop_now, done_flag, done_out;
    svnet_stream_meta_t [P_PPC-1:0] meta_in, meta_out;
    logic [META_W-1:0] pipe_in, pipe_out;

`ifdef SVNET_PIXMAP_TX_LOOP_EN
    assign loop_now = i_loop;
`else
    assign loop_now = 1'b0;
`endif

    assign issue     = (state_q == RUN) && !i_hold;
    assign last_word = (word_q == words_m1_q);
    assign last_row  = (row_q == rows_m1_q);
    assign done_flag = issue && last_word && last_row && !loop_now;

    // NOTE: every *_d takes its default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        words_m1_d = words_m1_q;
        rows_m1_d  = rows_m1_q;
        word_d     = word_q;
        row_d      = row_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        zero_done  = 1'b0;
        start_w    = (i_width > WIDTH_W'(P_WIDTH)) ? WIDTH_W'(P_WIDTH) : i_width;
        start_h    = (i_height > HEIGHT_W'(P_HEIGHT)) ? HEIGHT_W'(P_HEIGHT) : i_height;
        case (state_q)
            IDLE: if (i_start) begin
                if (start_w == '0 || start_h == '0) begin
                    zero_done = 1'b1;
                end else begin
                    state_d    = RUN;
                    width_d    = start_w;
                    words_m1_d = WORD_W'((int'(start_w) + P_PPC - 1) / P_PPC - 1);
                    rows_m1_d  = ROW_W'(int'(start_h) - 1);
                end
            end
            RUN: if (issue) begin
                if (!last_word) begin
                    word_d = word_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end else if (!last_row) begin
                    word_d     = '0;
                    row_d      = row_q + 1'b1;
                    row_base_d = row_base_q + ADDR_W'(WPR);
                    addr_d     = row_base_d;
                end else begin
                    // Counters return to zero so a looped frame restarts at address 0.
                    word_d     = '0;
                    row_d      = '0;
                    addr_d     = '0;
                    row_base_d = '0;
                    if (!loop_now) state_d = DRAIN;
                end
            end
            DRAIN: if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        meta_in = '0;
        for (int l = 0; l < P_PPC; l++) begin
            meta_in[l].valid     = issue && (int'(word_q) * P_PPC + l < int'(width_q));
            meta_in[l].row_end   = issue && (int'(word_q) * P_PPC + l == int'(width_q) - 1);
            meta_in[l].frame_end = meta_in[l].row_end && last_row;
        end
    end

    assign pipe_in = {done_flag, meta_in};

    svnet_stream_delay #(
        .DEPTH (RD_LATENCY),
        .WIDTH (META_W)
    ) u_meta_delay (
        .clk (clk),
        .rst (rst),
        .d_i (pipe_in),
        .q_o (pipe_out)
    );

    assign {done_out, meta_out} = pipe_out;

    // Lanes without a valid pixel are forced to zero rather than passing stale RAM data.
    always_comb begin
        valid_d     = '0;
        row_end_d   = '0;
        frame_end_d = '0;
        data_d      = '0;
        for (int l = 0; l < P_PPC; l++) begin
            valid_d[l]     = meta_out[l].valid;
            row_end_d[l]   = meta_out[l].row_end;
            frame_end_d[l] = meta_out[l].frame_end;
            if (meta_out[l].valid) data_d[l*P_BPP +: P_BPP] = bus.i_rd_data[l*P_BPP +: P_BPP];
        end
        done_d = zero_done | done_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            words_m1_q  <= '0;
            rows_m1_q   <= '0;
            word_q      <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            row_base_q  <= '0;
            done_q      <= 1'b0;
            valid_q     <= '0;
            row_end_q   <= '0;
            frame_end_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            words_m1_q  <= words_m1_d;
            rows_m1_q   <= rows_m1_d;
            word_q      <= word_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            row_base_q  <= row_base_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            row_end_q   <= row_end_d;
            frame_end_q <= frame_end_d;
            data_q      <= data_d;
        end
    end

    assign o_busy          = (state_q != IDLE);
    assign o_done          = done_q;
    assign bus.o_rd_en     = issue;
    assign bus.o_rd_addr   = addr_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_row_end   = row_end_q;
    assign bus.o_frame_end = frame_end_q;
    assign bus.o_data      = data_q;
endmodule
